// File: rtl/cic_interpolator_if.sv
// Port bundle for cic_interpolator: run-time configuration, low-rate sample
// strobe/request pair and the high-rate output stream.
interface cic_interpolator_if #(
   parameter int INBITWIDTH  = 16,
   parameter int EXTBITWIDTH = 43
);
   logic        [4:0]             cic_order;
   logic        [4:0]             cic_interp_factor;
   logic signed [INBITWIDTH-1:0]  din;
   logic                          din_flag;
   logic                          din_req;
   logic signed [EXTBITWIDTH-1:0] dout;
   logic                          dout_flag;

   modport master (
      output cic_order, cic_interp_factor, din, din_flag,
      input  din_req, dout, dout_flag
   );

   modport slave (
      input  cic_order, cic_interp_factor, din, din_flag,
      output din_req, dout, dout_flag
   );
endinterface

// File: rtl/cic_interpolator.sv
// Five-stage CIC interpolator with run-time order (3/4/5) and ratio (1..32).
// Define CIC_INTERP_STATUS_EN to add registered underrun/overrun pulse outputs.
module cic_interpolator #(
   parameter int INBITWIDTH  = 16,
   parameter int EXTBITWIDTH = 43
) (
   input  logic              clk,
   input  logic              rst,
   cic_interpolator_if.slave bus
`ifdef CIC_INTERP_STATUS_EN
   ,
   output logic              underrun,
   output logic              overrun
`endif
);
   localparam int NST = 5;
   typedef logic signed [EXTBITWIDTH-1:0] ext_t;

   logic [4:0] icnt;
   logic [4:0] icnt_next;
   logic       inj;
   logic [2:0] ord;
   logic       pending;
   logic [2:0] lat_cnt;
   ext_t       hold_p0;
   ext_t       x_p0;
   ext_t       c [0:NST];
   ext_t       dly [0:NST-1];
   ext_t       comb_sel;
   ext_t       u_p1;
   ext_t       integ [0:NST-1];
   ext_t       int_sel;

   function automatic ext_t sext(input logic signed [INBITWIDTH-1:0] v);
      return ext_t'(v);
   endfunction

   always_comb begin
      case (bus.cic_order)
         5'd4:    ord = 3'd4;
         5'd5:    ord = 3'd5;
         default: ord = 3'd3;
      endcase
   end

   assign inj       = (icnt == 5'd0);
   assign icnt_next = (icnt >= bus.cic_interp_factor) ? 5'd0 : icnt + 5'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         icnt        <= '0;
         bus.din_req <= 1'b0;
      end else begin
         icnt        <= icnt_next;
         bus.din_req <= (icnt_next == bus.cic_interp_factor);
      end
   end

   // Stage p0: sample hold; a strobe in the injection cycle bypasses the hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_p0 <= '0;
         pending <= 1'b0;
      end else if (inj) begin
         pending <= 1'b0;
      end else if (bus.din_flag) begin
         hold_p0 <= sext(bus.din);
         pending <= 1'b1;
      end
   end

   always_comb begin
      x_p0 = '0;
      if (inj) begin
         if (bus.din_flag)
            x_p0 = sext(bus.din);
         else if (pending)
            x_p0 = hold_p0;
      end
   end

   always_comb begin
      ext_t acc;
      acc = x_p0;
      for (int k = 0; k < NST; k++) begin
         c[k] = acc;
         acc  = acc - dly[k];
      end
      c[NST] = acc;
      case (ord)
         3'd4:    comb_sel = c[4];
         3'd5:    comb_sel = c[5];
         default: comb_sel = c[3];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NST; k++) dly[k] <= '0;
      end else if (inj) begin
         for (int k = 0; k < NST; k++) dly[k] <= c[k];
      end
   end

   // Stage p1: zero-stuffer feeding the integrator chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) u_p1 <= '0;
      else      u_p1 <= inj ? comb_sel : '0;
   end

   // Stage p2: integrators run modulo 2^EXTBITWIDTH; wrap cancels with the combs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NST; k++) integ[k] <= '0;
         bus.dout <= '0;
      end else begin
         integ[0] <= integ[0] + u_p1;
         for (int k = 1; k < NST; k++) integ[k] <= integ[k] + integ[k-1];
         bus.dout <= int_sel;
      end
   end

   always_comb begin
      case (ord)
         3'd4:    int_sel = integ[3];
         3'd5:    int_sel = integ[4];
         default: int_sel = integ[2];
      endcase
   end

   // Output valid once the first injection has travelled ord+2 cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_cnt       <= '0;
         bus.dout_flag <= 1'b0;
      end else begin
         if ((inj || lat_cnt != 3'd0) && lat_cnt != 3'd7)
            lat_cnt <= lat_cnt + 3'd1;
         bus.dout_flag <= (lat_cnt > ord);
      end
   end

`ifdef CIC_INTERP_STATUS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         underrun <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         underrun <= inj && !pending && !bus.din_flag;
         overrun  <= bus.din_flag && pending;
      end
   end
`endif
endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator: an FIR reference (boxcar^N impulse
// response applied to the zero-stuffed injections) feeds an expected-output queue.
module tb_cic_interpolator;
   localparam int IW   = 16;
   localparam int EW   = 43;
   localparam int MAXC = 1024;

   logic clk;
   logic rst;
`ifdef CIC_INTERP_STATUS_EN
   logic underrun;
   logic overrun;
`endif

   cic_interpolator_if #(.INBITWIDTH(IW), .EXTBITWIDTH(EW)) bus ();

   cic_interpolator #(.INBITWIDTH(IW), .EXTBITWIDTH(EW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef CIC_INTERP_STATUS_EN
      ,
      .underrun (underrun),
      .overrun  (overrun)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   longint          h [0:255];
   int              hlen;
   longint          xh [0:MAXC-1];
   logic [EW-1:0]   exp_q [$];
   longint          src_q [$];
   longint          src_def;
   int              ord, fac, lead, cyc, micnt;
   bit              serve_en;
   bit              mpend;
   longint          mhold;
   bit              exp_ur, exp_ov;
   logic [EW-1:0]   dc_exp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic set_cfg(input int o, input int f);
      longint t [0:255];
      bus.cic_order         = 5'(o);
      bus.cic_interp_factor = 5'(f);
      ord = (o == 4) ? 4 : (o == 5) ? 5 : 3;
      fac = f;
      for (int i = 0; i < 256; i++) h[i] = 0;
      h[0] = 1;
      hlen = 1;
      repeat (ord) begin
         for (int i = 0; i < 256; i++) t[i] = 0;
         for (int i = 0; i < hlen; i++)
            for (int j = 0; j <= f; j++) t[i+j] += h[i];
         hlen += f;
         for (int i = 0; i < 256; i++) h[i] = t[i];
      end
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0;
      bus.din_flag = 1'b0;
      bus.din = '0;
      #1;
      check("rst_dout", 64'($unsigned(bus.dout)), 64'd0);
      check("rst_dout_flag", 64'(bus.dout_flag), 64'd0);
      check("rst_din_req", 64'(bus.din_req), 64'd0);
`ifdef CIC_INTERP_STATUS_EN
      check("rst_underrun", 64'(underrun), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
`endif
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      cyc = 0; micnt = 0; mpend = 1'b0; mhold = 0;
      exp_ur = 1'b0; exp_ov = 1'b0;
      for (int i = 0; i < MAXC; i++) xh[i] = 0;
      exp_q.delete();
      for (int i = 0; i < ord + 2; i++) exp_q.push_back('0);
   endtask

   task automatic tick(input bit flag, input logic signed [IW-1:0] d);
      logic [EW-1:0] exp_dout;
      longint        x, e;
      bit            ur_n, ov_n;
      @(negedge clk);
      exp_dout = exp_q.pop_front();
      check("dout", 64'($unsigned(bus.dout)), 64'(exp_dout));
      check("dout_flag", 64'(bus.dout_flag), 64'(cyc >= ord + 2));
      check("din_req", 64'(bus.din_req), 64'((cyc > 0) && (micnt == fac)));
`ifdef CIC_INTERP_STATUS_EN
      check("underrun", 64'(underrun), 64'(exp_ur));
      check("overrun", 64'(overrun), 64'(exp_ov));
`endif
      bus.din_flag = flag;
      bus.din      = d;
      ur_n = 1'b0;
      ov_n = flag && mpend;
      if (micnt == 0) begin
         x    = flag ? longint'(d) : (mpend ? mhold : 0);
         ur_n = !flag && !mpend;
         mpend = 1'b0;
      end else begin
         x = 0;
         if (flag) begin
            mhold = longint'(d);
            mpend = 1'b1;
         end
      end
      if (cyc < MAXC) xh[cyc] = x;
      e = 0;
      for (int m = 0; m < hlen; m++)
         if (cyc - m >= 0 && cyc - m < MAXC) e += h[m] * xh[cyc-m];
      exp_q.push_back(e[EW-1:0]);
      exp_ur = ur_n;
      exp_ov = ov_n;
      micnt  = (micnt >= fac) ? 0 : micnt + 1;
      cyc++;
   endtask

   task automatic run(input int n);
      bit                   s;
      logic signed [IW-1:0] d;
      for (int i = 0; i < n; i++) begin
         s = serve_en && (micnt == fac - lead) && (cyc > 0 || fac == 0);
         d = '0;
         if (s) d = IW'((src_q.size() > 0) ? src_q.pop_front() : src_def);
         tick(s, d);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.din = '0;
      bus.din_flag = 1'b0;
      bus.cic_order = 5'd3;
      bus.cic_interp_factor = 5'd3;
      serve_en = 1'b1;
      lead = 0;
      ord = 3; fac = 3; cyc = 0; micnt = 0;

      // Impulse response, order 3, R=4
      set_cfg(3, 3);
      src_q.delete(); src_q.push_back(1); src_def = 0;
      do_reset();
      run(60);

      // DC gain, order 3, R=4
      set_cfg(3, 3);
      src_q.delete(); src_def = 1;
      do_reset();
      run(60);
      check("dc_o3_r4", 64'($unsigned(bus.dout)), 64'd16);

      // Reset in the middle of a DC run, then re-settle
      do_reset();
      run(60);
      check("dc_after_reset", 64'($unsigned(bus.dout)), 64'd16);

      // DC gain, order 4, R=2
      set_cfg(4, 1);
      do_reset();
      run(40);
      check("dc_o4_r2", 64'($unsigned(bus.dout)), 64'd8);

      // DC gain, order 5, R=32, most negative input
      set_cfg(5, 31);
      src_def = -32768;
      do_reset();
      run(400);
      dc_exp = EW'(-(64'sd1 <<< 35));
      check("dc_o5_r32", 64'($unsigned(bus.dout)), 64'(dc_exp));

      // R=1: sample every cycle, bypass path
      set_cfg(3, 0);
      src_def = 1;
      do_reset();
      run(30);
      check("dc_r1", 64'($unsigned(bus.dout)), 64'd1);

      // Handshake, factor 7, samples 3 cycles early, out-of-range order code
      set_cfg(9, 7);
      lead = 3;
      src_q.delete();
      src_q.push_back(100); src_q.push_back(-250); src_q.push_back(7);
      src_q.push_back(-32768); src_q.push_back(32767); src_q.push_back(1);
      src_def = 0;
      do_reset();
      run(120);
      lead = 0;

`ifdef CIC_INTERP_STATUS_EN
      // Underrun by withholding one sample, then overrun by a double strobe
      set_cfg(3, 3);
      src_q.delete(); src_def = 1;
      do_reset();
      run(20);
      serve_en = 1'b0;
      run(4);
      serve_en = 1'b1;
      run(12);
      for (int i = 0; i < 4 && micnt != 1; i++) run(1);
      tick(1'b1, 16'sd5);
      tick(1'b1, 16'sd9);
      tick(1'b0, 16'sd0);
      run(30);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
